seq_mul: RTL and testbench
==========================

SEQ_MUL -- requirements
Module: seq_mul

Interface
REQ-001 Parameter: XLEN, 32, operand and result width; only 32 is supported.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_valid  input  1  operands and op presented.
REQ-006 Port: in_ready  output  1  block idle and able to accept.
REQ-007 Port: a  input  XLEN  multiplicand (rs1).
REQ-008 Port: b  input  XLEN  multiplier (rs2).
REQ-009 Port: op  input  2  mul_op_t: MUL=0, MULH=1, MULHSU=2, MULHU=3.
REQ-010 Port: out_valid  output  1  result valid.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: s  output  XLEN  result; feeds the EX-stage result mux.

Function
REQ-013 FSM states SHALL be IDLE, RUN, FIX and DONE.
REQ-014 in_ready SHALL be high only in IDLE and when rst is low.
REQ-015 Accept: in_valid && in_ready at an edge; latch a, b, op and the operand signs; go to RUN.
REQ-016 Signedness: a is signed for MUL, MULH and MULHSU; b is signed for MUL and MULH; unsigned otherwise.
REQ-017 In RUN, the block SHALL hold the absolute values in a 64-bit multiplicand register mc and a 32-bit multiplier register mp.
REQ-018 Each RUN cycle: if mp[0], acc <= acc + mc (64-bit, wrap); mc <= mc << 1; mp <= mp >> 1; iteration counter +1.
REQ-019 RUN SHALL exit to FIX after exactly 32 iterations (see REQ-029 for early exit).
REQ-020 FIX (one cycle): negate acc (two's complement, 64-bit) if the effective signs differ; s <= op==MUL ? acc[31:0] : acc[63:32]; go to DONE.
REQ-021 DONE: out_valid high; s stable until out_valid && out_ready, then go to IDLE.
REQ-022 Latency: out_valid SHALL first assert 34 edges after the accept edge; the next accept is possible no earlier than the edge after the result handshake.
REQ-023 Backpressure: out_ready held low keeps DONE, out_valid and s indefinitely, and in_ready stays 0.
REQ-024 in_valid while in_ready is low SHALL be ignored, with no state change.
REQ-025 Most-negative operand: |0x80000000| = 2^31 SHALL be handled as an unsigned magnitude, with no overflow.

Reset
REQ-026 rst high at an edge SHALL force IDLE, out_valid=0, s=0, acc=0 and counter=0 from any state, including mid-RUN; in-flight work is discarded.
REQ-027 in_ready SHALL be 0 while rst is high and 1 on the first cycle after rst deasserts.

Configuration
REQ-028 Macro SEQ_MUL_EARLY_OUT_EN selects early exit from RUN.
REQ-029 With SEQ_MUL_EARLY_OUT_EN defined: RUN exits to FIX at the first edge where the next mp is 0 or 32 iterations are done. b=0 gives 1 RUN cycle, so out_valid asserts 3 edges after accept.
REQ-030 Without SEQ_MUL_EARLY_OUT_EN: the fixed 32-iteration latency of REQ-022 applies; results are identical in both builds.

Structure
REQ-031 Package mul_pkg SHALL hold mul_op_t, the state enum type and constants XLEN=32 and MUL_ITERS=32.
REQ-032 The 64-bit accumulate adder SHALL be the sub-module seq_mul_add (ports a, b, s; 64-bit, combinational); seq_mul SHALL instantiate it once.

Verification
REQ-033 After reset: in_ready=1, out_valid=0, s=0.
REQ-034 MUL with a=3, b=5 -> s=15; out_valid exactly 34 edges after accept (non-early-out build).
REQ-035 MULH with a=b=0xFFFFFFFF -> s=0x00000000; MULHU with the same operands -> s=0xFFFFFFFE.
REQ-036 MULHSU with a=0xFFFFFFFF, b=0xFFFFFFFF -> s=0xFFFFFFFF. MUL with a=b=0x80000000 -> s=0x00000000. MULH with the same operands -> s=0x40000000.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> s and out_valid stable, in_ready=0; a new in_valid is ignored until the result handshake.
REQ-038 Reset and early-out:
- rst pulsed at RUN iteration 10 -> IDLE next cycle, out_valid never asserts.
- Early-out build, MUL with a=7, b=0 -> s=0, out_valid 3 edges after accept.
- Early-out build, b=1 -> s=a.
- 1000 random ops compared against a reference model.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential multiplier.
// The operation encoding matches the ISA M-extension multiply group.
package mul_pkg;

    localparam int XLEN      = 32;
    localparam int MUL_ITERS = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mul_state_t;

    // rs1 is treated as signed for every op except MULHU.
    function automatic logic a_is_signed(input mul_op_t op);
        return op != OP_MULHU;
    endfunction

    // rs2 is treated as signed only for MUL and MULH.
    function automatic logic b_is_signed(input mul_op_t op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

    // Magnitude of a possibly negative operand. The most negative value
    // maps onto itself, which is exactly 2^31 read as an unsigned number.
    function automatic logic [XLEN-1:0] abs_mag(input logic [XLEN-1:0] v,
                                                input logic            neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/seq_mul_add.sv
// 64-bit combinational adder shared by accumulation and final negation.
module seq_mul_add (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] s
);

    assign s = a + b;

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-and-add multiplier (MUL/MULH/MULHSU/MULHU), one bit of
// the multiplier per RUN cycle, magnitudes multiplied and the sign fixed
// up in a single FIX cycle.
// Optional build macro: SEQ_MUL_EARLY_OUT_EN leaves RUN as soon as the
// remaining multiplier bits are all zero.
// Reset is synchronous and active-high.
module seq_mul #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    input  mul_pkg::mul_op_t   op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    s
);

    import mul_pkg::*;

    localparam logic [5:0] LAST_ITER = 6'(MUL_ITERS - 1);

    mul_state_t          state;
    mul_state_t          state_nxt;
    mul_op_t             op_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   mc;
    logic [XLEN-1:0]     mp;
    logic [2*XLEN-1:0]   acc;
    logic [5:0]          iter_cnt;

    logic                accept;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     mp_nxt;
    logic                run_last;
    logic [2*XLEN-1:0]   add_a;
    logic [2*XLEN-1:0]   add_b;
    logic [2*XLEN-1:0]   add_s;
    logic [2*XLEN-1:0]   fixed;

    assign in_ready = (state == S_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign a_neg    = a[XLEN-1] && a_is_signed(op);
    assign b_neg    = b[XLEN-1] && b_is_signed(op);
    assign mp_nxt   = mp >> 1;

`ifdef SEQ_MUL_EARLY_OUT_EN
    assign run_last = (iter_cnt == LAST_ITER) || (mp_nxt == '0);
`else
    assign run_last = (iter_cnt == LAST_ITER);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept)                 state_nxt = S_RUN;
            S_RUN:  if (run_last)               state_nxt = S_FIX;
            S_FIX:                              state_nxt = S_DONE;
            S_DONE: if (out_valid && out_ready) state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    // Adder operand select: accumulate mc in RUN, add one to ~acc in FIX.
    always_comb begin
        add_a = acc;
        add_b = mc;
        if (state == S_FIX) begin
            add_a = ~acc;
            add_b = {{(2*XLEN-1){1'b0}}, 1'b1};
        end
    end

    seq_mul_add u_add (
        .a (add_a),
        .b (add_b),
        .s (add_s)
    );

    assign fixed = neg_q ? add_s : acc;

    // Datapath: operand capture, shift-and-add, sign fix-up, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: <= in clocked blocks so every register samples pre-edge values.
            op_q      <= OP_MUL;
            neg_q     <= 1'b0;
            mc        <= '0;
            mp        <= '0;
            acc       <= '0;
            iter_cnt  <= '0;
            s         <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= op;
                        neg_q    <= a_neg ^ b_neg;
                        mc       <= {{XLEN{1'b0}}, abs_mag(a, a_neg)};
                        mp       <= abs_mag(b, b_neg);
                        acc      <= '0;
                        iter_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (mp[0]) begin
                        acc <= add_s;
                    end
                    mc       <= mc << 1;
                    mp       <= mp_nxt;
                    iter_cnt <= iter_cnt + 6'd1;
                end
                S_FIX: begin
                    acc <= fixed;
                    s   <= (op_q == OP_MUL) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
                end
                S_DONE: begin
                    // Result flag rises one cycle into DONE and drops on handshake.
                    out_valid <= !(out_valid && out_ready);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul.sv
// Self-checking bench for seq_mul: directed vector table, backpressure,
// mid-RUN reset and randomized operations against an arithmetic model.
module tb_seq_mul;

    import mul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    mul_op_t     op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;

    int total = 0;
    int bad   = 0;

    seq_mul #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full-width product of sign/zero extended operands, then pick the half.
    function automatic logic [31:0] ref_mul(input mul_op_t o, input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] xe;
        logic [63:0] ye;
        logic [63:0] p;
        xe = (o != OP_MULHU) ? {{32{x[31]}}, x} : {32'b0, x};
        ye = (o == OP_MUL || o == OP_MULH) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = xe * ye;
        return (o == OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    // Edges from accept to first out_valid.
    function automatic int ref_lat(input mul_op_t o, input logic [31:0] y);
`ifdef SEQ_MUL_EARLY_OUT_EN
        logic [31:0] mag;
        int          n;
        mag = ((o == OP_MUL || o == OP_MULH) && y[31]) ? (32'd0 - y) : y;
        n = 1;
        for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
        return n + 2;
`else
        return 34;
`endif
    endfunction

    task automatic wait_ready(output bit ok);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        ok = in_ready;
        if (!ok) check("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // Issue one op and wait (bounded) for out_valid; does not handshake.
    task automatic run_op(input mul_op_t o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat);
        bit ok;
        wait_ready(ok);
        in_valid = 1'b1;
        a = x;
        b = y;
        op = o;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = s;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        mul_op_t     o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs[8];
        logic [31:0] res;
        logic [31:0] held;
        int          lat;
        bit          seen;

        vecs[0] = '{"mul_3x5",      OP_MUL,    32'd3,          32'd5,          32'd15};
        vecs[1] = '{"mulh_m1",      OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
        vecs[2] = '{"mulhu_max",    OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
        vecs[3] = '{"mulhsu_max",   OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[4] = '{"mul_minneg",   OP_MUL,    32'h8000_0000,  32'h8000_0000,  32'h0000_0000};
        vecs[5] = '{"mulh_minneg",  OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
        vecs[6] = '{"mul_b0",       OP_MUL,    32'd7,          32'd0,          32'd0};
        vecs[7] = '{"mul_b1",       OP_MUL,    32'h1234_5678,  32'd1,          32'h1234_5678};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        op = OP_MUL;
        repeat (3) @(posedge clk);
        #1;
        check("in_ready_in_rst", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_s", 64'(s), 64'd0);

        // Directed vectors including the signed corner cases.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].o, vecs[i].x, vecs[i].y, res, lat);
            check({vecs[i].name, "_s"}, 64'(res), 64'(vecs[i].exp));
            check({vecs[i].name, "_lat"}, 64'(lat), 64'(ref_lat(vecs[i].o, vecs[i].y)));
            handshake();
            check({vecs[i].name, "_ready_after"}, 64'(in_ready), 64'd1);
        end

        // Backpressure: result held, new requests ignored until handshake.
        run_op(OP_MULHU, 32'hDEAD_BEEF, 32'h0BAD_F00D, res, lat);
        held = ref_mul(OP_MULHU, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        check("bp_first", 64'(res), 64'(held));
        in_valid = 1'b1;
        a = 32'd9;
        b = 32'd9;
        op = OP_MUL;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_s", 64'(s), 64'(held));
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        handshake();
        check("bp_done_valid", 64'(out_valid), 64'd0);
        check("bp_done_ready", 64'(in_ready), 64'd1);
        check("bp_s_kept", 64'(s), 64'(held));

        // Reset at RUN iteration 10 discards the operation.
        in_valid = 1'b1;
        a = 32'd1000;
        b = 32'hFFFF_FFFF;
        op = OP_MULHU;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_s", 64'(s), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_result", 64'(seen), 64'd0);
        run_op(OP_MUL, 32'd6, 32'd7, res, lat);
        check("midrst_next_s", 64'(res), 64'd42);
        handshake();

        // Randomized ops with corner-biased operands.
        for (int n = 0; n < 1000; n++) begin
            mul_op_t     ro;
            logic [31:0] rx;
            logic [31:0] ry;
            ro = mul_op_t'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: rx = 32'h8000_0000;
                1: ry = 32'hFFFF_FFFF;
                2: ry = $urandom_range(0, 15);
                3: rx = '0;
                default: ;
            endcase
            run_op(ro, rx, ry, res, lat);
            check("rand_s", 64'(res), 64'(ref_mul(ro, rx, ry)));
            check("rand_lat", 64'(lat), 64'(ref_lat(ro, ry)));
            handshake();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
